// File: rtl/reg_sel_encoder.sv
// Multi-hot register-request to serial address encoder: round-robin pick, registered output, valid/ready.
// Build option ENC_FIXED_PRIO_EN: lowest-index-first pick, no round-robin pointer.
module reg_sel_encoder #(
  parameter int N_REQ   = 32,
  parameter int ADDR_W  = 5,
  parameter int SKIP_X0 = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [N_REQ-1:0]  req_vec_in,
  input  logic              sel_ready_in,
  output logic              sel_valid_out,
  output logic [ADDR_W-1:0] sel_addr_out,
  output logic [N_REQ-1:0]  grant_ack_out,
  output logic              pending_out,
  output logic              dbg_state_out
);

  // Handshake: a transfer happens in any cycle with sel_valid_out=1 and sel_ready_in=1.
  // While valid is high and ready is low, sel_addr_out is held stable; ready is ignored while valid is low.

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [ADDR_W-1:0]  w_base;
  logic [ADDR_W-1:0]  w_pick;
  logic               w_found;
  logic               w_accept;
  logic [N_REQ-1:0]   w_hold_mask;
  logic [N_REQ-1:0]   w_skip_mask;
  logic [N_REQ-1:0]   w_elig;

  assign sel_valid_out = (r_state == ST_FULL);
  assign sel_addr_out  = r_addr;
  assign dbg_state_out = r_state;
  assign w_accept      = sel_valid_out & sel_ready_in;

  // The held index is masked so a line still high after its grant cannot win twice.
  assign w_hold_mask   = sel_valid_out ? (N_REQ'(1) << r_addr) : '0;
  assign w_skip_mask   = (SKIP_X0 != 0) ? {{(N_REQ-1){1'b1}}, 1'b0} : '1;
  assign w_elig        = req_vec_in & ~w_hold_mask & w_skip_mask;
  assign pending_out   = |w_elig;
  assign grant_ack_out = w_accept ? (N_REQ'(1) << r_addr) : '0;

`ifdef ENC_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [ADDR_W-1:0] r_ptr;

  // On accept the search starts just past the address leaving, i.e. at the pointer value being written.
  assign w_base = sel_valid_out ? (r_addr + ADDR_W'(1)) : r_ptr;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= r_addr + ADDR_W'(1);
    end
  end
`endif

  always_comb begin
    logic [ADDR_W-1:0] v_idx;
    v_idx   = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = w_base + ADDR_W'(i);
      if (!w_found && w_elig[v_idx]) begin
        w_pick  = v_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      ST_EMPTY: begin
        if (w_found) begin
          w_addr_nxt  = w_pick;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (sel_ready_in) begin
          if (w_found) begin
            w_addr_nxt = w_pick;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_EMPTY;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

endmodule

// File: tb/tb_reg_sel_encoder.sv
// Bench for reg_sel_encoder: directed scenarios plus random requesters against a behavioural model.
module tb_reg_sel_encoder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] req_vec_in;
  logic        sel_ready_in;
  logic        sel_valid_out;
  logic [4:0]  sel_addr_out;
  logic [31:0] grant_ack_out;
  logic        pending_out;
  logic        dbg_state_out;

  logic        z_valid;
  logic [4:0]  z_addr;
  logic [31:0] z_ack;
  logic        z_pend;
  logic        z_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  exp_q[$];
  int          m_valid;
  int          m_addr;
  int          m_ptr;
  int          wait_cnt[32];
  int          max_wait = 0;

  reg_sel_encoder u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_vec_in(req_vec_in), .sel_ready_in(sel_ready_in),
    .sel_valid_out(sel_valid_out), .sel_addr_out(sel_addr_out), .grant_ack_out(grant_ack_out),
    .pending_out(pending_out), .dbg_state_out(dbg_state_out)
  );

  reg_sel_encoder #(.SKIP_X0(0)) u_dut_x0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_vec_in(req_vec_in), .sel_ready_in(sel_ready_in),
    .sel_valid_out(z_valid), .sel_addr_out(z_addr), .grant_ack_out(z_ack),
    .pending_out(z_pend), .dbg_state_out(z_dbg)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [31:0] e, input int base);
    int b;
    b = base;
`ifdef ENC_FIXED_PRIO_EN
    b = 0;
`endif
    for (int i = 0; i < 32; i++) begin
      if (e[(b + i) % 32]) return (b + i) % 32;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_elig(input logic [31:0] req);
    logic [31:0] e;
    e = req;
    if (m_valid != 0) e[m_addr] = 1'b0;
    e[0] = 1'b0;
    return e;
  endfunction

  // Called at a falling edge; applies inputs, checks, advances the model, returns at the next falling edge.
  task automatic step(input logic [31:0] req, input logic rdy, output logic [31:0] acked);
    logic [31:0] e;
    logic [31:0] exp_ack;
    req_vec_in   = req;
    sel_ready_in = rdy;
    #1;
    e       = model_elig(req);
    exp_ack = (m_valid != 0 && rdy) ? (32'd1 << m_addr) : 32'd0;
    check_eq("valid", 32'(sel_valid_out), 32'(m_valid));
    if (m_valid != 0) check_eq("addr", 32'(sel_addr_out), 32'(m_addr));
    check_eq("ack", grant_ack_out, exp_ack);
    check_eq("pending", 32'(pending_out), 32'(e != 0));
    check_eq("dbg_state", 32'(dbg_state_out), 32'(m_valid));
    if (exp_ack != 0) begin
      if (exp_q.size() > 0) check_eq("grant_order", 32'(sel_addr_out), 32'(exp_q.pop_front()));
      for (int k = 1; k < 32; k++) begin
        if (k != m_addr && req[k]) wait_cnt[k]++;
      end
      wait_cnt[m_addr] = 0;
      for (int k = 1; k < 32; k++) if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
    end
    if (m_valid == 0) begin
      if (e != 0) begin
        m_addr  = model_pick(e, m_ptr);
        m_valid = 1;
      end
    end else if (rdy) begin
      m_ptr = (m_addr + 1) % 32;
      if (e != 0) m_addr = model_pick(e, m_ptr);
      else m_valid = 0;
    end
    acked = exp_ack;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Requesters hold each line until they see its ack.
  task automatic run_req(input logic [31:0] req, input logic rdy, input int n);
    logic [31:0] r;
    logic [31:0] a;
    r = req;
    repeat (n) begin
      step(r, rdy, a);
      r &= ~a;
    end
  endtask

  // Asserts reset between clock edges so the asynchronous path is what clears the outputs.
  task automatic do_reset(input logic [31:0] req);
    req_vec_in   = req;
    sel_ready_in = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("rst_valid", 32'(sel_valid_out), 32'd0);
    check_eq("rst_addr", 32'(sel_addr_out), 32'd0);
    check_eq("rst_ack", grant_ack_out, 32'd0);
    m_valid = 0;
    m_addr  = 0;
    m_ptr   = 0;
    for (int k = 0; k < 32; k++) wait_cnt[k] = 0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    rst_n_in     = 1'b0;
    req_vec_in   = '1;
    sel_ready_in = 1'b0;
    @(negedge clk_in);

    // Reset with every line requesting, then release: x01 is the first grant.
    do_reset(32'hFFFF_FFFF);
    run_req(32'hFFFF_FFFF, 1'b0, 1);
    check_eq("first_grant_valid", 32'(sel_valid_out), 32'd1);
    check_eq("first_grant_addr", 32'(sel_addr_out), 32'd1);

    // Single request.
    do_reset(32'd0);
    step(32'h0000_0020, 1'b1, a);
    check_eq("single_addr", 32'(sel_addr_out), 32'd5);
    step(32'h0000_0020, 1'b1, a);
    check_eq("single_ack", a, 32'h0000_0020);
    run_req(32'd0, 1'b1, 1);
    check_eq("single_drain", 32'(sel_valid_out), 32'd0);

    // Backpressure then back-to-back grants.
    do_reset(32'd0);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd2);
    run_req(32'h0000_0006, 1'b0, 5);
    check_eq("bp_hold_addr", 32'(sel_addr_out), 32'd1);
    r = 32'h0000_0006;
    step(r, 1'b1, a);
    r &= ~a;
    check_eq("bp_no_bubble", {sel_valid_out, 26'd0, sel_addr_out}, {1'b1, 26'd0, 5'd2});
    run_req(r, 1'b1, 2);
    check_eq("bp_order_done", 32'(exp_q.size()), 32'd0);

    // Move the pointer to 31, then test wrap order.
    do_reset(32'd0);
    run_req(32'h4000_0000, 1'b1, 3);
`ifdef ENC_FIXED_PRIO_EN
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd31);
`else
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd2);
`endif
    run_req(32'h8000_0004, 1'b1, 5);
    check_eq("wrap_order_done", 32'(exp_q.size()), 32'd0);

    // x00 request: masked here, granted by the SKIP_X0=0 instance.
    do_reset(32'd0);
    step(32'h0000_0001, 1'b1, a);
    check_eq("x0_z_valid", 32'(z_valid), 32'd1);
    check_eq("x0_z_addr", 32'(z_addr), 32'd0);
    check_eq("x0_z_dbg", 32'(z_dbg), 32'd1);
    check_eq("x0_z_pending", 32'(z_pend), 32'd0);
    check_eq("x0_z_ack", z_ack, 32'h0000_0001);
    step(32'h0000_0001, 1'b1, a);
    check_eq("x0_masked_valid", 32'(sel_valid_out), 32'd0);

    // Reset while holding x07 under backpressure.
    do_reset(32'd0);
    run_req(32'h0000_0080, 1'b0, 2);
    check_eq("hold_addr7", 32'(sel_addr_out), 32'd7);
    do_reset(32'h0000_0080);
    step(32'h0000_0080, 1'b1, a);
    check_eq("no_ack_after_rst", a, 32'd0);

    // Random requesters and ready.
    do_reset(32'd0);
    r = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) r |= 32'd1 << $urandom_range(0, 31);
      if ($urandom_range(0, 40) == 0) r |= $urandom;
      step(r, ($urandom_range(0, 3) != 0), a);
      r &= ~a;
    end
`ifndef ENC_FIXED_PRIO_EN
    check_eq("fairness_wait_le_31", 32'(max_wait <= 31), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
